// File: rtl/s_output_arbiter_if.sv
// rtl/s_output_arbiter_if.sv - request/grant/flit/credit bundle for one router output port arbiter
interface s_output_arbiter_if #(
    parameter int NUM_IN = 3,
    parameter int CNT_W  = 3
);
    logic [NUM_IN-1:0] req_i;
    logic [NUM_IN-1:0] tail_i;
    logic              credit_return_i;
    logic [NUM_IN-1:0] grant_o;
    logic [NUM_IN-1:0] read_o;
    logic              flit_valid_o;
    logic [NUM_IN-1:0] nhr_write_o;
    logic [CNT_W-1:0]  credits_o;
    logic              credit_err_o;

    modport slave (
        input  req_i,
        input  tail_i,
        input  credit_return_i,
        output grant_o,
        output read_o,
        output flit_valid_o,
        output nhr_write_o,
        output credits_o,
        output credit_err_o
    );

    modport master (
        output req_i,
        output tail_i,
        output credit_return_i,
        input  grant_o,
        input  read_o,
        input  flit_valid_o,
        input  nhr_write_o,
        input  credits_o,
        input  credit_err_o
    );
endinterface

// File: rtl/s_output_arbiter.sv
// rtl/s_output_arbiter.sv - round-robin wormhole arbiter with credit gating for one output port
module s_output_arbiter #(
    parameter int NUM_IN  = 3,
    parameter int CREDITS = 4,
    parameter int CNT_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    s_output_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [NUM_IN-1:0]  r_grant;
    logic [CNT_W-1:0]   r_credits;
    logic               r_credit_err;

    logic [IDX_W-1:0]   w_winner;
    logic               w_any_req;
    logic [NUM_IN-1:0]  w_owner_oh;
    logic [NUM_IN-1:0]  w_winner_oh;
    logic               w_send;
    logic               w_tail_out;

    // Round-robin search: first requester at or above rr_ptr, wrapping past NUM_IN-1.
    always_comb begin
        logic [IDX_W:0] v_pos;
        w_winner  = '0;
        w_any_req = 1'b0;
        v_pos     = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            v_pos = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (v_pos >= (IDX_W+1)'(NUM_IN)) begin
                v_pos = v_pos - (IDX_W+1)'(NUM_IN);
            end
            if (!w_any_req && bus.req_i[v_pos[IDX_W-1:0]]) begin
                w_any_req = 1'b1;
                w_winner  = v_pos[IDX_W-1:0];
            end
        end
    end

    assign w_owner_oh  = NUM_IN'(1) << r_owner;
    assign w_winner_oh = NUM_IN'(1) << w_winner;

    // A flit moves only when the owner has data and downstream has room.
    assign w_send     = (r_state == S_LOCKED) && bus.req_i[r_owner] && (r_credits != '0);
    assign w_tail_out = w_send && bus.tail_i[r_owner];

    assign bus.read_o       = w_send     ? w_owner_oh : '0;
    assign bus.nhr_write_o  = w_tail_out ? w_owner_oh : '0;
    assign bus.flit_valid_o = w_send;
    assign bus.grant_o      = r_grant;
    assign bus.credits_o    = r_credits;
    assign bus.credit_err_o = r_credit_err;

    // Packet lock FSM: arbitrate in IDLE, hold the owner until its tail flit leaves.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_grant  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_LOCKED;
                        r_owner <= w_winner;
                        r_grant <= w_winner_oh;
                    end
                end
                S_LOCKED: begin
                    if (w_tail_out) begin
                        r_state  <= S_IDLE;
                        r_grant  <= '0;
                        r_rr_ptr <= (r_owner == IDX_W'(NUM_IN - 1)) ? '0 : r_owner + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Credit counter runs regardless of lock state; a return with no free slot is flagged sticky.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_credits    <= CNT_W'(CREDITS);
            r_credit_err <= 1'b0;
        end else if (w_send && !bus.credit_return_i) begin
            r_credits <= r_credits - CNT_W'(1);
        end else if (!w_send && bus.credit_return_i) begin
            if (r_credits == CNT_W'(CREDITS)) begin
                r_credit_err <= 1'b1;
            end else begin
                r_credits <= r_credits + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_s_output_arbiter.sv
// tb/tb_s_output_arbiter.sv - table, directed and random checks of s_output_arbiter
module tb_s_output_arbiter;
    localparam int N = 3;
    localparam int C = 4;
    localparam int W = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    s_output_arbiter_if #(.NUM_IN(N), .CNT_W(W)) bus ();

    s_output_arbiter #(.NUM_IN(N), .CREDITS(C), .CNT_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_credits;
    bit m_err;

    logic [N-1:0] obs_grant, obs_read, obs_nhr;
    logic [W-1:0] obs_cred;
    logic         obs_err, obs_fv;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] tail;
        logic         ret;
        logic         rst;
        logic [N-1:0] g;
        logic [N-1:0] rd;
        logic [N-1:0] nhr;
        logic [W-1:0] cred;
        logic         err;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // One clock cycle: drive, check against model mid-cycle, advance model at the edge.
    task automatic step(input logic [N-1:0] rq, input logic [N-1:0] tl, input logic rt, input logic rs);
        int e_grant, e_read, e_nhr;
        bit send;
        bus.req_i           = rq;
        bus.tail_i          = tl;
        bus.credit_return_i = rt;
        reset               = rs;
        #4;
        send    = m_locked && rq[m_owner] && (m_credits > 0);
        e_grant = m_locked ? (1 << m_owner) : 0;
        e_read  = send ? (1 << m_owner) : 0;
        e_nhr   = (send && tl[m_owner]) ? (1 << m_owner) : 0;
        obs_grant = bus.grant_o;
        obs_read  = bus.read_o;
        obs_nhr   = bus.nhr_write_o;
        obs_cred  = bus.credits_o;
        obs_err   = bus.credit_err_o;
        obs_fv    = bus.flit_valid_o;
        chk("grant", 32'(obs_grant), e_grant);
        chk("read", 32'(obs_read), e_read);
        chk("flit_valid", 32'(obs_fv), 32'(send));
        chk("nhr_write", 32'(obs_nhr), e_nhr);
        chk("credits", 32'(obs_cred), m_credits);
        chk("credit_err", 32'(obs_err), 32'(m_err));
        @(posedge clk);
        if (!rs) begin
            m_locked  = 0;
            m_ptr     = 0;
            m_credits = C;
            m_err     = 0;
        end else begin
            if (!m_locked) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (rq[i]) begin
                        m_locked = 1;
                        m_owner  = i;
                        break;
                    end
                end
            end else if (send && tl[m_owner]) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % N;
            end
            if (send && !rt) m_credits--;
            else if (rt && !send) begin
                if (m_credits == C) m_err = 1;
                else m_credits++;
            end
        end
        #1;
    endtask

    initial begin
        int fair_g [8];
        tbl[0]  = '{3'b101, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'd4, 1'b0};
        tbl[1]  = '{3'b101, 3'b000, 1'b0, 1'b1, 3'b001, 3'b001, 3'b000, 3'd4, 1'b0};
        tbl[2]  = '{3'b101, 3'b001, 1'b0, 1'b1, 3'b001, 3'b001, 3'b001, 3'd3, 1'b0};
        tbl[3]  = '{3'b101, 3'b100, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'd2, 1'b0};
        tbl[4]  = '{3'b101, 3'b000, 1'b0, 1'b1, 3'b100, 3'b100, 3'b000, 3'd2, 1'b0};
        tbl[5]  = '{3'b101, 3'b100, 1'b1, 1'b1, 3'b100, 3'b100, 3'b100, 3'd1, 1'b0};
        tbl[6]  = '{3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 3'd1, 1'b0};
        tbl[7]  = '{3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 3'd2, 1'b0};
        tbl[8]  = '{3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 3'd3, 1'b0};
        tbl[9]  = '{3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'd4, 1'b0};
        tbl[10] = '{3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 3'd4, 1'b0};
        tbl[11] = '{3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'd4, 1'b1};
        tbl[12] = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'd4, 1'b1};
        tbl[13] = '{3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'd4, 1'b0};
        fair_g = '{0, 1, 0, 2, 0, 4, 0, 1};

        reset               = 1'b0;
        bus.req_i           = '0;
        bus.tail_i          = '0;
        bus.credit_return_i = 1'b0;
        @(posedge clk);
        #1;
        m_locked  = 0;
        m_owner   = 0;
        m_ptr     = 0;
        m_credits = C;
        m_err     = 0;

        // Table: 2-flit packets from inputs 0 and 2, credit returns, sticky error, reset
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].req, tbl[i].tail, tbl[i].ret, tbl[i].rst);
            chk($sformatf("tbl%0d_grant", i), 32'(obs_grant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_read", i), 32'(obs_read), 32'(tbl[i].rd));
            chk($sformatf("tbl%0d_nhr", i), 32'(obs_nhr), 32'(tbl[i].nhr));
            chk($sformatf("tbl%0d_credits", i), 32'(obs_cred), 32'(tbl[i].cred));
            chk($sformatf("tbl%0d_err", i), 32'(obs_err), 32'(tbl[i].err));
        end

        // Fairness: all inputs requesting single-flit packets
        step(3'b000, 3'b000, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            step(3'b111, 3'b111, logic'(c % 2), 1'b1);
            chk($sformatf("fair%0d_grant", c), 32'(obs_grant), fair_g[c]);
            chk($sformatf("fair%0d_read", c), 32'(obs_read), fair_g[c]);
            chk($sformatf("fair%0d_nhr", c), 32'(obs_nhr), fair_g[c]);
        end

        // Credit stall on a long packet, then a single returned credit
        step(3'b000, 3'b000, 1'b0, 1'b0);
        step(3'b001, 3'b000, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step(3'b001, 3'b000, 1'b0, 1'b1);
            chk($sformatf("stall_send%0d", c), 32'(obs_read), 1);
        end
        step(3'b001, 3'b000, 1'b0, 1'b1);
        chk("stall_credits0", 32'(obs_cred), 0);
        chk("stall_read0", 32'(obs_read), 0);
        step(3'b001, 3'b000, 1'b1, 1'b1);
        chk("stall_ret_read", 32'(obs_read), 0);
        step(3'b001, 3'b000, 1'b0, 1'b1);
        chk("stall_resume_read", 32'(obs_read), 1);
        chk("stall_resume_cred", 32'(obs_cred), 1);
        step(3'b001, 3'b000, 1'b0, 1'b1);
        chk("stall_again_read", 32'(obs_read), 0);

        // Owner bubble while input 1 requests
        step(3'b000, 3'b000, 1'b0, 1'b0);
        step(3'b001, 3'b000, 1'b0, 1'b1);
        step(3'b001, 3'b000, 1'b0, 1'b1);
        chk("bubble_first_read", 32'(obs_read), 1);
        for (int c = 0; c < 3; c++) begin
            step(3'b010, 3'b000, 1'b0, 1'b1);
            chk($sformatf("bubble%0d_grant", c), 32'(obs_grant), 1);
            chk($sformatf("bubble%0d_read", c), 32'(obs_read), 0);
        end
        step(3'b011, 3'b001, 1'b0, 1'b1);
        chk("bubble_tail_read", 32'(obs_read), 1);
        chk("bubble_tail_nhr", 32'(obs_nhr), 1);
        step(3'b010, 3'b000, 1'b0, 1'b1);
        chk("bubble_gap_grant", 32'(obs_grant), 0);
        step(3'b010, 3'b000, 1'b0, 1'b1);
        chk("bubble_next_grant", 32'(obs_grant), 2);

        // Mid-packet reset with one credit left and rr_ptr moved off 0
        step(3'b000, 3'b000, 1'b0, 1'b0);
        step(3'b001, 3'b001, 1'b0, 1'b1);
        step(3'b001, 3'b001, 1'b0, 1'b1);
        step(3'b010, 3'b000, 1'b0, 1'b1);
        step(3'b010, 3'b000, 1'b0, 1'b1);
        step(3'b010, 3'b000, 1'b0, 1'b1);
        step(3'b010, 3'b000, 1'b0, 1'b0);
        chk("mrst_cred_before", 32'(obs_cred), 1);
        step(3'b011, 3'b000, 1'b0, 1'b1);
        chk("mrst_grant", 32'(obs_grant), 0);
        chk("mrst_cred", 32'(obs_cred), 4);
        chk("mrst_read", 32'(obs_read), 0);
        chk("mrst_nhr", 32'(obs_nhr), 0);
        chk("mrst_fv", 32'(obs_fv), 0);
        step(3'b011, 3'b000, 1'b0, 1'b1);
        chk("mrst_ptr0_grant", 32'(obs_grant), 1);

        // Random traffic against the model
        step(3'b000, 3'b000, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            step(N'($urandom_range(0, 7)), N'($urandom_range(0, 7)),
                 logic'($urandom_range(0, 9) < 4), logic'($urandom_range(0, 199) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
